mips_dmem_responder: RTL and testbench



---
 rtl/mips_dmem_responder.sv | 121 ++++++++++++
 tb/tb_mips_dmem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// Stallable big-endian data memory answering 16-bit load/store requests with WAIT_CYCLES wait states.
// Optional DMEM_ALIGN_CHECK_EN: odd addresses are reported as errors instead of byte-pair accesses.
module mips_dmem_responder #(
  parameter int MEM_SIZE    = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on an edge where req_valid && req_ready; a response
  // transfers on an edge where rsp_valid && rsp_ready. Payloads hold steady while valid waits.

  localparam int          AW        = (MEM_SIZE > 2) ? $clog2(MEM_SIZE) : 1;
  localparam logic [15:0] ADDR_LIM  = 16'(MEM_SIZE - 1);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic            op_write;
  logic [15:0]     op_addr;
  logic [15:0]     op_wdata;
  logic            op_ok;
  logic            access_now;
  logic [AW-1:0]   idx_hi;
  logic [AW-1:0]   idx_lo;

  // Storage is zero at power-up and deliberately untouched by rst.
  logic [7:0] mem [MEM_SIZE] = '{default: 8'h00};

  always_comb begin
    op_ok = (op_addr < ADDR_LIM);
`ifdef DMEM_ALIGN_CHECK_EN
    if (op_addr[0]) op_ok = 1'b0;
`endif
    idx_hi     = op_addr[AW-1:0];
    idx_lo     = idx_hi + AW'(1);
    access_now = (state == S_WAIT) && (wait_cnt == 4'd0);
  end

  // A reset landing on the access edge aborts the store.
  always_ff @(posedge clk) begin
    if (!rst && access_now && op_write && op_ok) begin
      mem[idx_hi] <= op_wdata[15:8];
      mem[idx_lo] <= op_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      rsp_err   <= 1'b0;
      wait_cnt  <= 4'd0;
      op_write  <= 1'b0;
      op_addr   <= 16'h0000;
      op_wdata  <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_write  <= req_write;
            op_addr   <= req_addr;
            op_wdata  <= req_wdata;
            wait_cnt  <= WAIT_INIT;
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !op_ok;
            rsp_rdata <= (op_ok && !op_write) ? {mem[idx_hi], mem[idx_lo]} : 16'h0000;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

  a_no_overlap: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> !req_ready);
  a_ready_idle: assert property (@(posedge clk) disable iff (rst) req_ready == (state == S_IDLE));

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Randomized bench for mips_dmem_responder against a byte-array memory model and expected queue.
// Honours DMEM_ALIGN_CHECK_EN in the same way as the design.
module tb_mips_dmem_responder;
  localparam int MEM_SIZE    = 512;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  ref_mem [MEM_SIZE];
  logic [16:0] exp_q [$];

  mips_dmem_responder #(.MEM_SIZE(MEM_SIZE), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit ref_ok(input logic [15:0] a);
    bit ok;
    ok = (int'(a) < MEM_SIZE - 1);
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[0]) ok = 1'b0;
`endif
    return ok;
  endfunction

  // model update + scoreboard push for one request
  task automatic model_txn(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    bit ok;
    logic [15:0] rd;
    ok = ref_ok(a);
    rd = 16'h0000;
    if (ok && wr) begin
      ref_mem[int'(a)]     = wd[15:8];
      ref_mem[int'(a) + 1] = wd[7:0];
    end else if (ok) begin
      rd = {ref_mem[int'(a)], ref_mem[int'(a) + 1]};
    end
    exp_q.push_back({!ok, rd});
  endtask

  task automatic clear_req();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 16'h0000;
  endtask

  // driver: one complete transaction, holding rsp_ready low for bp cycles
  task automatic txn(input logic wr, input logic [15:0] a, input logic [15:0] wd, input int bp);
    int lat;
    logic [16:0] exp_v;
    model_txn(wr, a, wd);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    rsp_ready = (bp == 0);
    @(posedge clk); #1;
    clear_req();
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      check("req_ready_busy", req_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, WAIT_CYCLES + 1);
    exp_v = exp_q.pop_front();
    check("rsp_rdata", rsp_rdata, exp_v[15:0]);
    check("rsp_err", rsp_err, exp_v[16]);
    for (int i = 0; i < bp; i++) begin
      // a competing store that must be ignored while the response is pending
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0050; req_wdata = 16'hDEAD;
      @(posedge clk); #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, exp_v[15:0]);
      check("bp_err", rsp_err, exp_v[16]);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    clear_req();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 16'h0000);
    check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  initial begin
    int lat;
    logic [15:0] a;
    int r;
    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'h00;
    clear_req();
    rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("idle");

    // basic store/load
    txn(1'b1, 16'h0010, 16'hBEEF, 0);
    txn(1'b0, 16'h0010, 16'h0000, 0);
    txn(1'b0, 16'h0011, 16'h0000, 0);

    // bounds
    txn(1'b1, 16'h01FE, 16'hC0DE, 0);
    txn(1'b0, 16'h01FF, 16'h0000, 0);
    txn(1'b1, 16'h0200, 16'hFFFF, 1);
    txn(1'b1, 16'h01FF, 16'h1111, 0);
    txn(1'b0, 16'hFFFF, 16'h0000, 0);
    txn(1'b0, 16'h01FE, 16'h0000, 0);

    // backpressure with an ignored competing store, then read that location
    txn(1'b0, 16'h0010, 16'h0000, 5);
    txn(1'b0, 16'h0050, 16'h0000, 0);

    // reset on the commit edge of a store
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    clear_req();
    repeat (WAIT_CYCLES) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b0;
    check_reset_outputs("rst_wait");
    txn(1'b0, 16'h0020, 16'h0000, 0);

    // reset while a store response is pending: store already committed
    model_txn(1'b1, 16'h0030, 16'h5678);
    void'(exp_q.pop_front());
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0030; req_wdata = 16'h5678;
    @(posedge clk); #1;
    clear_req();
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("resp_latency", lat, WAIT_CYCLES + 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("rst_resp");
    txn(1'b0, 16'h0030, 16'h0000, 0);

    // reset and request on the same edge
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'h9999;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_req();
    check_reset_outputs("rst_req");
    @(posedge clk); #1;
    check("rst_req_ready_after", req_ready, 1);
    txn(1'b0, 16'h0040, 16'h0000, 0);

    // odd address byte-pair access
    txn(1'b1, 16'h0011, 16'hA55A, 0);
    txn(1'b0, 16'h0011, 16'h0000, 0);
    txn(1'b0, 16'h0010, 16'h0000, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 16'($urandom_range(0, MEM_SIZE - 1));
      else if (r < 9) a = 16'(MEM_SIZE - 3 + $urandom_range(0, 3));
      else            a = 16'($urandom_range(0, 65535));
      txn(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 3));
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
